fade_multi: RTL

//  Multi-channel LED fade engine: NUM_CH independent channels, each with its own

---
 rtl/fade_multi.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fade_multi.sv
// fade_multi: multi-channel LED fade engine.
//
// Each of NUM_CH channels runs its own phase sequencer and drives one PWM pin.
// One step prescaler and one PWM counter are shared by all channels.
//
// Build option:
//   FADE_HOLD_EN defined   -> RISE -> ON_HOLD -> FALL -> OFF_HOLD -> RISE
//   FADE_HOLD_EN undefined -> RISE -> FALL -> RISE (hold phases never entered)
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   run        1 = sequencing advances, 0 = levels/phases/prescaler frozen
//   pwm_out    PWM output per channel, bit i = channel i
//   level      current level, channel i at [i*LW +: LW]
//   phase      current phase (doubles as the per-channel FSM state),
//              channel i at [i*2 +: 2]
//              (RISE=00, FALL=01, ON_HOLD=10, OFF_HOLD=11)
//   step_tick  high for the one cycle whose closing edge updates the levels
module fade_multi #(
  parameter int NUM_CH        = 3,
  parameter int PWM_INTERVAL  = 1200,
  parameter int STEP_INTERVAL = 12000,
  parameter int STEPS         = 200,
  parameter int HOLD_STEPS    = 200,
  localparam int LW           = $clog2(PWM_INTERVAL + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  output logic [NUM_CH-1:0]    pwm_out,
  output logic [NUM_CH*LW-1:0] level,
  output logic [NUM_CH*2-1:0]  phase,
  output logic                 step_tick
);

  typedef enum logic [1:0] {
    RISE     = 2'b00,
    FALL     = 2'b01,
    ON_HOLD  = 2'b10,
    OFF_HOLD = 2'b11
  } phase_t;

  localparam int INC_VAL   = PWM_INTERVAL / STEPS;
  localparam int PW        = $clog2(STEP_INTERVAL);
  localparam int CW        = $clog2(PWM_INTERVAL);
  localparam int MAX_STEPS = (STEPS > HOLD_STEPS) ? STEPS : HOLD_STEPS;
  localparam int SW        = $clog2(MAX_STEPS);

  localparam logic [LW-1:0] FULL      = LW'(PWM_INTERVAL);
  localparam logic [LW-1:0] INC_LV    = LW'(INC_VAL);
  localparam logic [LW:0]   INC_EXT   = (LW+1)'(INC_VAL);
  localparam logic [LW:0]   FULL_EXT  = (LW+1)'(PWM_INTERVAL);
  localparam logic [PW-1:0] PSC_LAST  = PW'(STEP_INTERVAL - 1);
  localparam logic [CW-1:0] PWM_LAST  = CW'(PWM_INTERVAL - 1);
  localparam logic [SW-1:0] RF_LAST   = SW'(STEPS - 1);
  localparam logic [SW-1:0] HOLD_LAST = SW'(HOLD_STEPS - 1);

  // Staggered start so neighbouring LEDs are out of step with each other.
  function automatic phase_t start_phase(input int ch);
`ifdef FADE_HOLD_EN
    case (ch % 4)
      0:       return RISE;
      1:       return ON_HOLD;
      2:       return FALL;
      default: return OFF_HOLD;
    endcase
`else
    return (ch % 2 == 0) ? RISE : FALL;
`endif
  endfunction

  function automatic phase_t next_phase(input phase_t p);
`ifdef FADE_HOLD_EN
    case (p)
      RISE:    return ON_HOLD;
      ON_HOLD: return FALL;
      FALL:    return OFF_HOLD;
      default: return RISE;
    endcase
`else
    return (p == RISE) ? FALL : RISE;
`endif
  endfunction

  // Level a channel takes when it enters phase p.
  function automatic logic [LW-1:0] entry_level(input phase_t p);
    return (p == ON_HOLD || p == FALL) ? FULL : '0;
  endfunction

  function automatic logic [SW-1:0] last_step(input phase_t p);
    return (p == ON_HOLD || p == OFF_HOLD) ? HOLD_LAST : RF_LAST;
  endfunction

  // One in-phase step; the extra bit keeps the saturation test overflow-free.
  function automatic logic [LW-1:0] step_level(input phase_t p, input logic [LW-1:0] lv);
    logic [LW:0] ext;
    ext = {1'b0, lv};
    case (p)
      RISE:    return (ext + INC_EXT > FULL_EXT) ? FULL : lv + INC_LV;
      FALL:    return (ext < INC_EXT) ? '0 : lv - INC_LV;
      default: return lv;
    endcase
  endfunction

  logic [PW-1:0] prescaler;
  logic [CW-1:0] pwm_cnt;
  phase_t        phase_q  [NUM_CH];
  logic [LW-1:0] level_q  [NUM_CH];
  logic [SW-1:0] step_cnt [NUM_CH];

  // Pure decode: the edge that closes this cycle is the level-update edge.
  assign step_tick = run && (prescaler == PSC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        phase_q[i]  <= start_phase(i);
        level_q[i]  <= entry_level(start_phase(i));
        step_cnt[i] <= '0;
        // pwm_cnt resets to 0, so the compare is simply level != 0.
        pwm_out[i]  <= (entry_level(start_phase(i)) != '0);
      end
    end else begin
      // The PWM counter free-runs so the LEDs keep their brightness while frozen.
      pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      if (run) begin
        prescaler <= (prescaler == PSC_LAST) ? '0 : prescaler + 1'b1;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_out[i] <= (LW'(pwm_cnt) < level_q[i]);
        if (step_tick) begin
          if (step_cnt[i] == last_step(phase_q[i])) begin
            // Snapping to the entry value absorbs the floor remainder of INC_VAL.
            step_cnt[i] <= '0;
            phase_q[i]  <= next_phase(phase_q[i]);
            level_q[i]  <= entry_level(next_phase(phase_q[i]));
          end else begin
            step_cnt[i] <= step_cnt[i] + 1'b1;
            level_q[i]  <= step_level(phase_q[i], level_q[i]);
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign level[g*LW +: LW] = level_q[g];
    assign phase[g*2 +: 2]   = phase_q[g];
  end

endmodule
